spi_req_arbiter: RTL
====================

// Module: spi_req_arbiter
// PURPOSE
//  Shares one 15-bit SPI_MASTER between N_REQ requesters: round-robin grant, drives the
//  master's st/DI, tracks its LOAD handshake, returns the received word to the winner.
//  Sits between client FSMs (DAC/ADC/config) and the single SPI_MASTER instance.
//  Adds start-timeout detection and a minimum idle gap between transfers.
// PARAMETERS
//  N_REQ    4   number of requesters (2..8)
//  DW       15  SPI word width, equals master DI/DO width
//  TIMEOUT  8   clk cycles allowed in S_START for spi_load to fall before err
//  GAP      2   idle clk cycles enforced after done before next grant (0 allowed)
// PORTS
//  clk       in   1         system clock, all state on posedge
//  clr       in   1         asynchronous active-high reset
//  req       in   N_REQ     request bits, level, held until own done bit
//  req_data  in   N_REQ*DW  TX words, requester i at [i*DW +: DW]
//  gnt       out  N_REQ     one-hot grant, high from grant edge to done edge
//  done      out  N_REQ     one-cycle pulse on granted bit at end of transaction
//  rx_data   out  DW        word received; valid with done, held until next done
//  err       out  1         one-cycle pulse with done when start timed out
//  busy      out  1         high in any state except S_IDLE
//  spi_st    out  1         to master st
//  spi_di    out  DW        to master DI
//  spi_load  in   1         from master LOAD (1 = idle/loading)
//  spi_do    in   DW        from master DO (updated on LOAD rise)
// BEHAVIOUR
//  Reset: state=S_IDLE, gnt=0, done=0, rx_data=0, err=0, busy=0, spi_st=0, spi_di=0,
//   rr pointer=N_REQ-1 (req[0] highest priority first), gap counter=0. clr mid-transfer
//   abandons it with no done; clr is also routed to the master's clr.
//  S_IDLE: if gap cnt!=0 decrement, no grant. Else if req!=0: pick first set bit
//   scanning ptr+1, ptr+2 ... wrapping mod N_REQ; same edge: gnt<=onehot(i), ptr<=i,
//   spi_di<=req_data[i], spi_st<=1, timeout cnt<=0, -> S_START.
//  S_START: spi_st held 1. spi_load==0 -> spi_st<=0, -> S_BUSY.
//   Else cnt==TIMEOUT-1 -> spi_st<=0, -> S_FAIL; else cnt++.
//  S_BUSY: spi_di held stable; wait spi_load==1 -> S_CAPT. No timeout (xfer ~3000 clk).
//  S_CAPT: one settle cycle; next edge rx_data<=spi_do, done<=gnt, gnt<=0,
//   gap cnt<=GAP, -> S_IDLE.
//  S_FAIL: one cycle; next edge rx_data<=0, done<=gnt, err<=1, gnt<=0, gap<=GAP, -> S_IDLE.
//  Latency: grant edge -> spi_st high same edge; spi_load rise -> done 2 clk later.
//  req dropped after grant: transaction completes, done still pulses. req_data sampled
//   only at grant edge. New req while busy: queued by level, arbitrated in S_IDLE.
//  Same requester re-requesting immediately with others pending loses to them (pointer).
//  done/err are registered, never combinational from req. Undefined states -> S_IDLE.
// TESTING
//  1 reset, req=4'b0001 data0=15'h5A5A -> gnt=0001, spi_st 1 until load falls,
//    master MISO loopback -> done=0001, rx_data=15'h5A5A, err=0.
//  2 req=4'b1111 held -> grant order 0,1,2,3,0; >=GAP idle cycles between done and gnt.
//  3 spi_load tied 1, req=4'b0100 -> after 8 clk in S_START: done=0100, err=1,
//    rx_data=0, spi_st=0; next request still serviced normally.
//  4 req[2] dropped mid-transfer -> done[2] still pulses, no extra grant to 2.
//  5 clr asserted in S_BUSY -> all outputs 0 next cycle, no done; req=0001 after
//    release -> normal transfer.
//  6 GAP=0, req=0011 -> grant 0 then 1 on cycle right after done[0].

Source files
------------

// File: rtl/spi_req_arbiter.sv
// spi_req_arbiter: round-robin front end for a single 15-bit SPI master.
// Grants one requester at a time, launches the master with st/DI, follows the
// LOAD handshake, returns DO to the winner with a done pulse, flags start
// timeouts with err, and enforces an idle gap between transfers.
`timescale 1ns/1ps

module spi_req_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DW      = 15,
    parameter int TIMEOUT = 8,
    parameter int GAP     = 2
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    done,
    output logic [DW-1:0]       rx_data,
    output logic                err,
    output logic                busy,
    output logic                spi_st,
    output logic [DW-1:0]       spi_di,
    input  logic                spi_load,
    input  logic [DW-1:0]       spi_do
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GAP + 2);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_BUSY  = 3'd2,
        S_CAPT  = 3'd3,
        S_FAIL  = 3'd4
    } state_t;

    state_t              r_state;
    logic [N_REQ-1:0]    r_gnt;
    logic [N_REQ-1:0]    r_done;
    logic [DW-1:0]       r_rx;
    logic                r_err;
    logic                r_st;
    logic [DW-1:0]       r_di;
    logic [PW-1:0]       r_ptr;
    logic [TW-1:0]       r_tcnt;
    logic [GW-1:0]       r_gcnt;

    state_t              w_state_nxt;
    logic [N_REQ-1:0]    w_gnt_nxt;
    logic [N_REQ-1:0]    w_done_nxt;
    logic [DW-1:0]       w_rx_nxt;
    logic                w_err_nxt;
    logic                w_st_nxt;
    logic [DW-1:0]       w_di_nxt;
    logic [PW-1:0]       w_ptr_nxt;
    logic [TW-1:0]       w_tcnt_nxt;
    logic [GW-1:0]       w_gcnt_nxt;

    logic                w_found;
    logic [PW-1:0]       w_idx;
    logic [PW-1:0]       w_cand;
    logic [N_REQ-1:0]    w_onehot;
    logic [DW-1:0]       w_sel_data;

    assign gnt     = r_gnt;
    assign done    = r_done;
    assign rx_data = r_rx;
    assign err     = r_err;
    assign spi_st  = r_st;
    assign spi_di  = r_di;
    assign busy    = (r_state != S_IDLE);

    // Round-robin search: first set request bit after the last winner, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand = PW'((int'(r_ptr) + k) % N_REQ);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
    end

    // Decode the winner into a one-hot grant and pick its TX word.
    always_comb begin
        w_onehot   = '0;
        w_sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_idx == PW'(i)) begin
                w_onehot[i] = 1'b1;
                w_sel_data  = req_data[i*DW +: DW];
            end
        end
    end

    // Next-state and next-output logic; done/err are single-cycle by default.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_done_nxt  = '0;
        w_rx_nxt    = r_rx;
        w_err_nxt   = 1'b0;
        w_st_nxt    = r_st;
        w_di_nxt    = r_di;
        w_ptr_nxt   = r_ptr;
        w_tcnt_nxt  = r_tcnt;
        w_gcnt_nxt  = r_gcnt;
        case (r_state)
            S_IDLE: begin
                if (r_gcnt != '0) begin
                    w_gcnt_nxt = r_gcnt - 1'b1;
                end else if (w_found) begin
                    w_gnt_nxt   = w_onehot;
                    w_ptr_nxt   = w_idx;
                    w_di_nxt    = w_sel_data;
                    w_st_nxt    = 1'b1;
                    w_tcnt_nxt  = '0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (!spi_load) begin
                    w_st_nxt    = 1'b0;
                    w_state_nxt = S_BUSY;
                end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
                    w_st_nxt    = 1'b0;
                    w_state_nxt = S_FAIL;
                end else begin
                    w_tcnt_nxt  = r_tcnt + 1'b1;
                end
            end
            S_BUSY: begin
                // A full transfer takes thousands of clocks, so no watchdog here.
                if (spi_load) begin
                    w_state_nxt = S_CAPT;
                end
            end
            S_CAPT: begin
                // DO settled one cycle after LOAD rose.
                w_rx_nxt    = spi_do;
                w_done_nxt  = r_gnt;
                w_gnt_nxt   = '0;
                w_gcnt_nxt  = GW'(GAP);
                w_state_nxt = S_IDLE;
            end
            S_FAIL: begin
                w_rx_nxt    = '0;
                w_done_nxt  = r_gnt;
                w_err_nxt   = 1'b1;
                w_gnt_nxt   = '0;
                w_gcnt_nxt  = GW'(GAP);
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_gnt_nxt   = '0;
                w_st_nxt    = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers; clr abandons any transfer without a done.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_done  <= '0;
            r_rx    <= '0;
            r_err   <= 1'b0;
            r_st    <= 1'b0;
            r_di    <= '0;
            r_ptr   <= PW'(N_REQ - 1);
            r_tcnt  <= '0;
            r_gcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_done  <= w_done_nxt;
            r_rx    <= w_rx_nxt;
            r_err   <= w_err_nxt;
            r_st    <= w_st_nxt;
            r_di    <= w_di_nxt;
            r_ptr   <= w_ptr_nxt;
            r_tcnt  <= w_tcnt_nxt;
            r_gcnt  <= w_gcnt_nxt;
        end
    end

endmodule
